// File: rtl/rca_seq_adder.sv
// rca_seq_adder: multi-byte adder/subtractor that time-shares one 8-bit
// ripple-carry adder, one byte per clock, LSB first, carry chained in a flop.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start, sub, cin  request pulse, mode (1 = a-b), carry-in for add mode
//   a, b             8*WORDS-bit operands, sampled with an accepted start
//   sum, cout, ovf   registered result, final carry, signed overflow
//   busy, done       slices in flight / one-cycle result-valid pulse

// RCA_8bit: existing 8-bit ripple-carry adder datapath.
// Ports: a, b 8-bit addends; ci carry-in; s 8-bit sum; co carry-out.
module RCA_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic [8:0] c;

  // Bit-serial ripple of the carry through eight full adders.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[8];
  end

endmodule

module rca_seq_adder #(
  parameter int unsigned WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sub,
  input  logic               cin,
  input  logic [8*WORDS-1:0] a,
  input  logic [8*WORDS-1:0] b,
  output logic [8*WORDS-1:0] sum,
  output logic               cout,
  output logic               ovf,
  output logic               busy,
  output logic               done
);

  localparam int unsigned W     = 8 * WORDS;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned SEL_W = IDX_W + 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SEL_W-1:0]   sel_lsb;
  logic [7:0]         rca_a;
  logic [7:0]         rca_b;
  logic [7:0]         rca_s;
  logic               rca_co;
  logic               last_slice;

  // Bit offset of the active slice.
  assign sel_lsb    = {idx_q, 3'b000};
  assign rca_a      = a_q[sel_lsb +: 8];
  assign rca_b      = b_q[sel_lsb +: 8];
  assign last_slice = (idx_q == IDX_W'(WORDS - 1));

  RCA_8bit u_rca (
    .a  (rca_a),
    .b  (rca_b),
    .ci (carry_q),
    .s  (rca_s),
    .co (rca_co)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (start) begin
          // Subtract is a + ~b + 1: invert B up front, seed carry with 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | cin;
          idx_d   = '0;
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        sum_d[sel_lsb +: 8] = rca_s;
        carry_d             = rca_co;
        if (last_slice) begin
          // Hold idx at the top slice rather than wrapping.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cout_d  = rca_co;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (rca_s[7] != a_q[W-1]);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_rca_seq_adder.sv
// tb_rca_seq_adder: directed vector table, handshake/reset sequences and
// randomized operations checked against an arithmetic reference model.
module tb_rca_seq_adder;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 8 * WORDS;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic         done;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[8];

  rca_seq_adder #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the full operand width.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic msub, input logic mcin,
                       output logic [W-1:0] rs, output logic rc, output logic ro);
    longint sa, sb, r;
    logic [W:0] full;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msub) begin
      rs = ma - mb;
      rc = (ma >= mb);
      r  = sa - sb;
    end else begin
      full = {1'b0, ma} + {1'b0, mb} + (W+1)'(mcin);
      rs   = full[W-1:0];
      rc   = full[W];
      r    = sa + sb + longint'(mcin);
    end
    ro = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endtask

  // Called at a negedge: presents a request and returns at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tsub, input logic tcin);
    a = ta; b = tb; sub = tsub; cin = tcin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts rising edges until done is seen; busy must stay high before that.
  task automatic wait_done(input string name, output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy !== 1'b1) chk({name, "_busy"}, 64'(busy), 64'd1);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (done !== 1'b1) chk({name, "_timeout"}, 64'(done), 64'd1);
  endtask

  task automatic check_result(input string name, input logic [W-1:0] es,
                              input logic ec, input logic eo);
    chk({name, "_sum"}, 64'(sum), 64'(es));
    chk({name, "_cout"}, 64'(cout), 64'(ec));
    chk({name, "_ovf"}, 64'(ovf), 64'(eo));
  endtask

  initial begin
    int n;
    int n2;
    logic [W-1:0] ms;
    logic mc, mo;
    logic [W-1:0] ra, rb;
    logic rsub, rcin;
    logic [W-1:0] held;

    n_cmp  = 0;
    n_fail = 0;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0};
    vecs[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[6] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[7] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    check_result("rst", '0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors with latency check.
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
      wait_done($sformatf("vec%0d", i), n);
      chk($sformatf("vec%0d_latency", i), 64'(n), 64'(WORDS));
      chk($sformatf("vec%0d_busy_at_done", i), 64'(busy), 64'd0);
      check_result($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
    end

    // Result holds and done drops after the pulse.
    held = sum;
    @(posedge clk);
    @(negedge clk);
    chk("hold_done", 64'(done), 64'd0);
    chk("hold_sum", 64'(sum), 64'(held));

    // Start pulsed again at edge 2 with other operands is ignored.
    start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", n);
    chk("ignore_latency", 64'(n), 64'd2);
    check_result("ignore", 32'h0000_0100, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("ignore_no_rerun", 64'(busy), 64'd0);

    // Start held high through DONE: second request accepted back-to-back.
    a = 32'h0000_0005; b = 32'h0000_0007; sub = 1'b1; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 32'h7FFF_FFFF; b = 32'h0000_0001; sub = 1'b0; cin = 1'b0;
    wait_done("b2b_first", n);
    chk("b2b_first_latency", 64'(n), 64'(WORDS));
    check_result("b2b_first", 32'hFFFF_FFFE, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accept_busy", 64'(busy), 64'd1);
    chk("b2b_accept_done", 64'(done), 64'd0);
    wait_done("b2b_second", n2);
    chk("b2b_gap", 64'(n2 + 1), 64'(WORDS + 1));
    check_result("b2b_second", 32'h8000_0000, 1'b0, 1'b1);

    // Leave cout/ovf set, then reset mid-operation.
    start_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    wait_done("pre_rst", n);
    check_result("pre_rst", 32'h0000_0000, 1'b1, 1'b1);
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    check_result("midrst", '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_idle", 64'(busy | done), 64'd0);
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_done("post_rst", n);
    chk("post_rst_latency", 64'(n), 64'(WORDS));
    check_result("post_rst", 32'h2345_6789, 1'b0, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra = {1'b0, {(W-1){1'b1}}} - W'($urandom_range(0, 3));
        1: rb = {1'b1, {(W-1){1'b0}}} + W'($urandom_range(0, 3));
        default: ;
      endcase
      rsub = 1'($urandom);
      rcin = 1'($urandom);
      model(ra, rb, rsub, rcin, ms, mc, mo);
      start_op(ra, rb, rsub, rcin);
      wait_done($sformatf("rnd%0d", i), n);
      chk($sformatf("rnd%0d_latency", i), 64'(n), 64'(WORDS));
      check_result($sformatf("rnd%0d", i), ms, mc, mo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
